// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: request size codes,
// controller states and lane widths.
package dm_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dm_lane_align.sv
// Little-endian lane steering: merges store data into the old word, extracts
// and extends load data, and flags illegal size/alignment combinations.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [1:0]        i_addr_lo,
   input  logic [1:0]        i_size,
   input  logic              i_sign,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [WORD_W-1:0] i_old_word,
   output logic [WORD_W-1:0] o_wr_word,
   output logic [WORD_W-1:0] o_rd_data,
   output logic              o_misalign
);

   logic [BYTE_W-1:0] w_byte;
   logic [HALF_W-1:0] w_half;

   always_comb begin
      o_wr_word  = i_old_word;
      o_rd_data  = '0;
      o_misalign = 1'b0;
      w_byte     = '0;
      w_half     = '0;
      case (i_size)
         SIZE_BYTE: begin
            w_byte = i_old_word[{i_addr_lo, 3'b000} +: BYTE_W];
            o_wr_word[{i_addr_lo, 3'b000} +: BYTE_W] = i_wdata[BYTE_W-1:0];
            o_rd_data = {{(WORD_W-BYTE_W){i_sign & w_byte[BYTE_W-1]}}, w_byte};
         end
         SIZE_HALF: begin
            o_misalign = i_addr_lo[0];
            w_half = i_old_word[{i_addr_lo[1], 4'b0000} +: HALF_W];
            o_wr_word[{i_addr_lo[1], 4'b0000} +: HALF_W] = i_wdata[HALF_W-1:0];
            o_rd_data = {{(WORD_W-HALF_W){i_sign & w_half[HALF_W-1]}}, w_half};
         end
         SIZE_WORD: begin
            o_misalign = |i_addr_lo;
            o_wr_word  = i_wdata;
            o_rd_data  = i_old_word;
         end
         default: o_misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding load/store at a time, LATENCY wait
// states between accept and access, registered response held until taken.
module dm_responder
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_sign;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic              r_req_ready;
   logic              r_resp_valid;
   logic [31:0]       r_resp_rdata;
   logic              r_resp_err;
   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

   logic [AW-1:0]     w_idx;
   logic [WORD_W-1:0] w_old_word;
   logic [WORD_W-1:0] w_wr_word;
   logic [WORD_W-1:0] w_rd_data;
   logic              w_misalign;
   logic              w_oor;
   logic              w_err;

   assign w_idx      = r_addr[AW+1:2];
   assign w_old_word = r_mem[w_idx];
   assign w_oor      = ({1'b0, r_addr} >= BYTE_LIMIT);
   assign w_err      = w_misalign | w_oor;

   dm_lane_align u_align (
      .i_addr_lo  (r_addr[1:0]),
      .i_size     (r_size),
      .i_sign     (r_sign),
      .i_wdata    (r_wdata),
      .i_old_word (w_old_word),
      .o_wr_word  (w_wr_word),
      .o_rd_data  (w_rd_data),
      .o_misalign (w_misalign)
   );

   // Reset also wipes the array, so an interrupted store never lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_size       <= SIZE_BYTE;
         r_sign       <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_size      <= req_size;
                  r_sign      <= req_sign;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_cnt       <= 4'(LATENCY);
                  r_req_ready <= 1'b0;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  if (w_err) begin
                     r_resp_err   <= 1'b1;
                     r_resp_rdata <= '0;
                  end else begin
                     if (r_we) begin
                        r_mem[w_idx] <= w_wr_word;
                     end
                     r_resp_err   <= 1'b0;
                     r_resp_rdata <= r_we ? '0 : w_rd_data;
                  end
                  r_resp_valid <= 1'b1;
                  r_state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_resp_rdata <= '0;
                  r_resp_err   <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed vector table, multi-cycle
// stall/reset sequences, a LATENCY=0 instance, and random traffic vs a byte model.
module tb_dm_responder;

   logic        clk;
   logic        reset;
   logic        reqValid, reqReady, reqWe, reqSign;
   logic [1:0]  reqSize;
   logic [31:0] reqAddr, reqWdata;
   logic        respValid, respReady, respErr;
   logic [31:0] respRdata;

   logic        zValid, zReady, zWe, zSign;
   logic [1:0]  zSize;
   logic [31:0] zAddr, zWdata;
   logic        zRespValid, zRespReady, zRespErr;
   logic [31:0] zRespRdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] modelMem [0:4095];

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      logic        expErr;
   } vec_t;

   vec_t vecs[$];

   dm_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (reqValid),
      .req_ready  (reqReady),
      .req_we     (reqWe),
      .req_size   (reqSize),
      .req_sign   (reqSign),
      .req_addr   (reqAddr),
      .req_wdata  (reqWdata),
      .resp_valid (respValid),
      .resp_ready (respReady),
      .resp_rdata (respRdata),
      .resp_err   (respErr)
   );

   dm_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (zValid),
      .req_ready  (zReady),
      .req_we     (zWe),
      .req_size   (zSize),
      .req_sign   (zSign),
      .req_addr   (zAddr),
      .req_wdata  (zWdata),
      .resp_valid (zRespValid),
      .resp_ready (zRespReady),
      .resp_rdata (zRespRdata),
      .resp_err   (zRespErr)
   );

   // Free-running 100 MHz clock; rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic void modelClear();
      for (int i = 0; i < 4096; i++) modelMem[i] = 8'h00;
   endfunction

   // Reference behaviour stated in terms of bytes: size in bytes, natural
   // alignment, range limit, little-endian assembly and extension.
   function automatic void modelAccess(input logic we, input logic [1:0] size, input logic sign,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
      int          nb;
      logic [31:0] val;
      nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
      rdata = '0;
      err   = (nb == 0);
      if (!err) err = (addr >= 32'd4096) || ((addr % 32'(nb)) != 32'd0);
      if (!err) begin
         if (we) begin
            for (int i = 0; i < nb; i++) modelMem[addr + 32'(i)] = wdata[8*i +: 8];
         end else begin
            val = '0;
            for (int i = 0; i < nb; i++) val = val | (32'(modelMem[addr + 32'(i)]) << (8*i));
            if (sign && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
            rdata = val;
         end
      end
   endfunction

   // One complete transaction on the LATENCY=2 instance; lat counts edges
   // from the accept edge to the first sample showing resp_valid.
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sign,
                                input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                                output logic [31:0] rdata, output logic err, output int lat);
      int n;
      n = 0;
      while (reqReady !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      reqValid = 1'b1; reqWe = we; reqSize = size; reqSign = sign; reqAddr = addr; reqWdata = wdata;
      @(posedge clk); #1;
      reqValid = 1'b0;
      reqWe    = 1'($urandom);
      reqSize  = 2'($urandom);
      reqSign  = 1'($urandom);
      reqAddr  = $urandom;
      reqWdata = $urandom;
      lat = 0;
      while (respValid !== 1'b1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
      end
      rdata = respRdata;
      err   = respErr;
      respReady = 1'b1;
      @(posedge clk); #1;
      respReady = 1'b0;
   endtask

   task automatic modelledAccess(input string name, input logic we, input logic [1:0] size,
                                 input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int stall);
      logic [31:0] expR, gotR;
      logic        expE, gotE;
      int          lat;
      modelAccess(we, size, sign, addr, wdata, expR, expE);
      applyStimulus(we, size, sign, addr, wdata, stall, gotR, gotE, lat);
      checkOutput({name, "_rdata"}, gotR, expR);
      checkOutput({name, "_err"}, 32'(gotE), 32'(expE));
      checkOutput({name, "_lat"}, 32'(lat), 32'd3);
   endtask

   task automatic applyFast(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                            output int lat);
      zValid = 1'b1; zWe = we; zSize = size; zSign = 1'b0; zAddr = addr; zWdata = wdata;
      @(posedge clk); #1;
      zValid = 1'b0;
      lat = 0;
      while (zRespValid !== 1'b1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = zRespRdata;
      err   = zRespErr;
      zRespReady = 1'b1;
      @(posedge clk); #1;
      zRespReady = 1'b0;
   endtask

   function automatic void addVec(input logic we, input logic [1:0] size, input logic sign,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] expRdata, input logic expErr);
      vec_t v;
      v.we = we; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
      v.expRdata = expRdata; v.expErr = expErr;
      vecs.push_back(v);
   endfunction

   initial begin
      logic [31:0] gotR, modR;
      logic        gotE, modE;
      int          lat;
      int          n;

      reset = 1'b0;
      reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'd0; reqSign = 1'b0; reqAddr = '0; reqWdata = '0;
      respReady = 1'b0;
      zValid = 1'b0; zWe = 1'b0; zSize = 2'd0; zSign = 1'b0; zAddr = '0; zWdata = '0;
      zRespReady = 1'b0;
      modelClear();

      #12;
      checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
      checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
      checkOutput("rst_resp_rdata", respRdata, 32'd0);
      checkOutput("rst_resp_err", 32'(respErr), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // we size sign addr wdata expRdata expErr
      addVec(1, 2'd2, 0, 32'h10,   32'h1234_5678, 32'h0000_0000, 0);
      addVec(0, 2'd2, 0, 32'h10,   32'h0,         32'h1234_5678, 0);
      addVec(1, 2'd0, 0, 32'h11,   32'hDEAD_BEAB, 32'h0000_0000, 0);
      addVec(0, 2'd2, 0, 32'h10,   32'h0,         32'h1234_AB78, 0);
      addVec(0, 2'd0, 1, 32'h11,   32'h0,         32'hFFFF_FFAB, 0);
      addVec(0, 2'd0, 0, 32'h11,   32'h0,         32'h0000_00AB, 0);
      addVec(1, 2'd1, 0, 32'h12,   32'h5555_8001, 32'h0000_0000, 0);
      addVec(0, 2'd1, 1, 32'h12,   32'h0,         32'hFFFF_8001, 0);
      addVec(0, 2'd1, 1, 32'h13,   32'h0,         32'h0000_0000, 1);
      addVec(0, 2'd2, 0, 32'h10,   32'h0,         32'h8001_AB78, 0);
      addVec(0, 2'd2, 0, 32'h1000, 32'h0,         32'h0000_0000, 1);
      addVec(0, 2'd3, 0, 32'h10,   32'h0,         32'h0000_0000, 1);
      addVec(1, 2'd3, 0, 32'h10,   32'hFFFF_FFFF, 32'h0000_0000, 1);
      addVec(1, 2'd2, 0, 32'h11,   32'hFFFF_FFFF, 32'h0000_0000, 1);
      addVec(1, 2'd1, 0, 32'h11,   32'hFFFF_FFFF, 32'h0000_0000, 1);
      addVec(0, 2'd2, 1, 32'h10,   32'h0,         32'h8001_AB78, 0);
      addVec(0, 2'd1, 0, 32'h10,   32'h0,         32'h0000_AB78, 0);
      addVec(0, 2'd1, 1, 32'h10,   32'h0,         32'hFFFF_AB78, 0);
      addVec(0, 2'd0, 1, 32'h13,   32'h0,         32'hFFFF_FF80, 0);
      addVec(0, 2'd0, 1, 32'h12,   32'h0,         32'h0000_0001, 0);
      addVec(1, 2'd2, 0, 32'hFFC,  32'hA1B2_C3D4, 32'h0000_0000, 0);
      addVec(0, 2'd2, 0, 32'hFFC,  32'h0,         32'hA1B2_C3D4, 0);
      addVec(0, 2'd0, 1, 32'hFFF,  32'h0,         32'hFFFF_FFA1, 0);
      addVec(0, 2'd1, 0, 32'hFFE,  32'h0,         32'h0000_A1B2, 0);
      addVec(0, 2'd0, 0, 32'h1000, 32'h0,         32'h0000_0000, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         modelAccess(vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata, modR, modE);
         applyStimulus(vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata, 0,
                       gotR, gotE, lat);
         checkOutput($sformatf("vec%0d_rdata", i), gotR, vecs[i].expRdata);
         checkOutput($sformatf("vec%0d_err", i), 32'(gotE), 32'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      end

      // Response held for 5 cycles while a competing store is offered.
      reqValid = 1'b1; reqWe = 1'b0; reqSize = 2'd2; reqSign = 1'b0; reqAddr = 32'h10; reqWdata = '0;
      @(posedge clk); #1;
      reqWe = 1'b1; reqAddr = 32'h40; reqWdata = 32'hCAFE_F00D;
      n = 0;
      while (respValid !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("stall_lat", 32'(n), 32'd3);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("stall%0d_valid", k), 32'(respValid), 32'd1);
         checkOutput($sformatf("stall%0d_rdata", k), respRdata, 32'h8001_AB78);
         checkOutput($sformatf("stall%0d_ready", k), 32'(reqReady), 32'd0);
      end
      respReady = 1'b1;
      @(posedge clk); #1;
      respReady = 1'b0;
      reqValid  = 1'b0;
      checkOutput("post_hs_req_ready", 32'(reqReady), 32'd1);
      checkOutput("post_hs_resp_valid", 32'(respValid), 32'd0);
      checkOutput("post_hs_resp_rdata", respRdata, 32'd0);
      modelledAccess("no_second_accept", 0, 2'd2, 0, 32'h40, 32'h0, 0);

      // Reset while a store to 0x20 sits in WAIT.
      reqValid = 1'b1; reqWe = 1'b1; reqSize = 2'd2; reqSign = 1'b0; reqAddr = 32'h20;
      reqWdata = 32'h5A5A_5A5A;
      @(posedge clk); #1;
      reqValid = 1'b0;
      @(posedge clk); #1;
      checkOutput("wait_req_ready", 32'(reqReady), 32'd0);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_rst_req_ready", 32'(reqReady), 32'd1);
      checkOutput("async_rst_resp_valid", 32'(respValid), 32'd0);
      #1 reset = 1'b1;
      modelClear();
      applyStimulus(0, 2'd2, 0, 32'h20, 32'h0, 0, gotR, gotE, lat);
      checkOutput("after_rst_0x20", gotR, 32'h0);
      applyStimulus(0, 2'd2, 0, 32'h10, 32'h0, 0, gotR, gotE, lat);
      checkOutput("after_rst_0x10", gotR, 32'h0);

      // Reset while a load response is pending in RESP.
      modelledAccess("pre_resp_rst_store", 1, 2'd2, 0, 32'h30, 32'h1357_2468, 0);
      reqValid = 1'b1; reqWe = 1'b0; reqSize = 2'd2; reqSign = 1'b0; reqAddr = 32'h30;
      @(posedge clk); #1;
      reqValid = 1'b0;
      n = 0;
      while (respValid !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("resp_before_rst", respRdata, 32'h1357_2468);
      #2 reset = 1'b0;
      #1;
      checkOutput("resp_rst_valid", 32'(respValid), 32'd0);
      checkOutput("resp_rst_rdata", respRdata, 32'd0);
      checkOutput("resp_rst_ready", 32'(reqReady), 32'd1);
      #1 reset = 1'b1;
      modelClear();
      modelledAccess("after_resp_rst", 0, 2'd2, 0, 32'h30, 32'h0, 0);

      // Random traffic concentrated in a small window so loads hit earlier stores.
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 32'h1FFF)) : 32'($urandom_range(0, 63));
         modelledAccess($sformatf("rand%0d", i), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                        int'($urandom_range(0, 2)));
      end

      // LATENCY=0 instance: response after the very next edge.
      applyFast(1, 2'd2, 32'h4, 32'h0BAD_BEEF, gotR, gotE, lat);
      checkOutput("lat0_store_lat", 32'(lat), 32'd1);
      checkOutput("lat0_store_err", 32'(gotE), 32'd0);
      applyFast(0, 2'd2, 32'h4, 32'h0, gotR, gotE, lat);
      checkOutput("lat0_load_lat", 32'(lat), 32'd1);
      checkOutput("lat0_load_rdata", gotR, 32'h0BAD_BEEF);
      applyFast(0, 2'd2, 32'h40, 32'h0, gotR, gotE, lat);
      checkOutput("lat0_oor_err", 32'(gotE), 32'd1);
      checkOutput("lat0_oor_rdata", gotR, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
